regfile_mp_sb: RTL and testbench

//  Parametrised multi-read-port register file with registered reads, write-first bypass and a
//  per-register busy scoreboard. Next-generation core register file: decode claims a destination,

---
 rtl/regfile_pkg.sv | 25 ++
 rtl/regfile_scoreboard.sv | 52 +++++
 rtl/regfile_mp_sb.sv | 106 ++++++++++
 tb/tb_regfile_mp_sb.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and index helpers for the multi-port register file.
// Build option: REGFILE_ZERO_REG_EN hard-wires register 0 to zero.
package regfile_pkg;

  localparam int unsigned DefDataW   = 32;
  localparam int unsigned DefNumRegs = 32;
  localparam int unsigned DefNumRd   = 2;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZeroRegEn = 1'b1;
`else
  localparam bit ZeroRegEn = 1'b0;
`endif

  // Address width for a register count; a single register still needs one address bit.
  function automatic int unsigned addr_w(input int unsigned num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

  // LSB of port p's field in a packed per-port bus.
  function automatic int unsigned port_lsb(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard: one pending-producer bit per register, priority rst > flush > claim > write.
// Honours REGFILE_ZERO_REG_EN (register 0 never reports busy).
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS = DefNumRegs,
  parameter int unsigned ADDR_W   = addr_w(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic                claim_en,
  input  logic [ADDR_W-1:0]   claim_addr,
  input  logic                flush,
  output logic [NUM_REGS-1:0] busy_next,
  output logic [NUM_REGS-1:0] busy_vec
);

  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] busy_q;

  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (wr_en && (32'(wr_addr) < NUM_REGS)) begin
        busy_d[wr_addr] = 1'b0;
      end
      // Applied after the clear so a same-cycle claim marks the new producer.
      if (claim_en && (32'(claim_addr) < NUM_REGS)) begin
        busy_d[claim_addr] = 1'b1;
      end
    end
    if (ZeroRegEn) begin
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_next = busy_d;
  assign busy_vec  = busy_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-read-port register file with registered reads, write-first bypass and busy scoreboard.
// Build option: REGFILE_ZERO_REG_EN makes register 0 a constant zero.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned NUM_REGS = DefNumRegs,
  parameter int unsigned NUM_RD   = DefNumRd,
  parameter int unsigned ADDR_W   = addr_w(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_addr,
  input  logic                     flush,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic [NUM_REGS-1:0]      busy_vec
);

  logic [DATA_W-1:0]        regs_q [NUM_REGS];
  logic                     wr_ok;
  logic [NUM_REGS-1:0]      busy_next;
  logic [ADDR_W-1:0]        rd_addr_u [NUM_RD];
  logic [DATA_W-1:0]        rd_data_d [NUM_RD];
  logic [NUM_RD-1:0]        rd_busy_d;
  logic [NUM_RD*DATA_W-1:0] rd_data_q;
  logic [NUM_RD-1:0]        rd_valid_q;
  logic [NUM_RD-1:0]        rd_busy_q;

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .flush      (flush),
    .busy_next  (busy_next),
    .busy_vec   (busy_vec)
  );

  always_comb begin
    wr_ok = wr_en && (32'(wr_addr) < NUM_REGS) && !(ZeroRegEn && (wr_addr == '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_ok) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Read value as it will be after this edge: bypassed write data and updated busy bits.
  always_comb begin
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      rd_addr_u[p] = rd_addr[port_lsb(p, ADDR_W) +: ADDR_W];
      rd_data_d[p] = '0;
      rd_busy_d[p] = 1'b0;
      if (32'(rd_addr_u[p]) < NUM_REGS) begin
        rd_busy_d[p] = busy_next[rd_addr_u[p]];
        if (wr_ok && (wr_addr == rd_addr_u[p])) begin
          rd_data_d[p] = wr_data;
        end else begin
          rd_data_d[p] = regs_q[rd_addr_u[p]];
        end
      end
      if (ZeroRegEn && (rd_addr_u[p] == '0)) begin
        rd_data_d[p] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= '0;
      rd_data_q  <= '0;
      rd_busy_q  <= '0;
    end else begin
      rd_valid_q <= rd_en;
      for (int unsigned p = 0; p < NUM_RD; p++) begin
        if (rd_en[p]) begin
          rd_data_q[port_lsb(p, DATA_W) +: DATA_W] <= rd_data_d[p];
          rd_busy_q[p]                             <= rd_busy_d[p];
        end
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_busy  = rd_busy_q;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb (24 registers, 2 read ports): directed vector table, then random
// traffic checked against an array-based reference model.
module tb_regfile_mp_sb;

  localparam int NR = 24;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit Z = 1'b1;
`else
  localparam bit Z = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        claim_en;
  logic [4:0]  claim_addr;
  logic        flush;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_valid;
  logic [1:0]  rd_busy;
  logic [23:0] busy_vec;

  always #5 clk = ~clk;

  regfile_mp_sb #(
    .DATA_W   (32),
    .NUM_REGS (NR),
    .NUM_RD   (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .flush      (flush),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_busy    (rd_busy),
    .busy_vec   (busy_vec)
  );

  typedef struct packed {
    logic        rst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        claim_en;
    logic [4:0]  claim_addr;
    logic        flush;
    logic [1:0]  rd_en;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [1:0]  e_valid;
    logic [31:0] e_d0;
    logic [31:0] e_d1;
    logic        e_b0;
    logic        e_b1;
    logic [23:0] e_bv;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: architectural register contents, busy set and per-port output latches.
  logic [31:0] m_mem [NR];
  logic        m_busy [NR];
  logic [31:0] m_data [2];
  logic        m_bsy [2];
  logic [1:0]  m_valid;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] model_busy_vec();
    logic [23:0] v;
    for (int i = 0; i < NR; i++) v[i] = m_busy[i];
    return v;
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    logic [4:0] a;
    if (rst) begin
      for (int i = 0; i < NR; i++) begin
        m_mem[i]  = '0;
        m_busy[i] = 1'b0;
      end
      m_valid = '0;
      for (int p = 0; p < 2; p++) begin
        m_data[p] = '0;
        m_bsy[p]  = 1'b0;
      end
    end else begin
      if (wr_en && int'(wr_addr) < NR && !(Z && wr_addr == 5'd0)) m_mem[wr_addr] = wr_data;
      if (flush) begin
        for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
      end else begin
        if (wr_en && int'(wr_addr) < NR) m_busy[wr_addr] = 1'b0;
        if (claim_en && int'(claim_addr) < NR) m_busy[claim_addr] = 1'b1;
      end
      if (Z) m_busy[0] = 1'b0;
      for (int p = 0; p < 2; p++) begin
        m_valid[p] = rd_en[p];
        a = (p == 0) ? rd_addr[4:0] : rd_addr[9:5];
        if (rd_en[p]) begin
          m_data[p] = (int'(a) < NR) ? m_mem[a] : 32'd0;
          m_bsy[p]  = (int'(a) < NR) ? m_busy[a] : 1'b0;
        end
      end
    end
  endtask

  task automatic apply(input vec_t v);
    rst        = v.rst;
    wr_en      = v.wr_en;
    wr_addr    = v.wr_addr;
    wr_data    = v.wr_data;
    claim_en   = v.claim_en;
    claim_addr = v.claim_addr;
    flush      = v.flush;
    rd_en      = v.rd_en;
    rd_addr    = {v.a1, v.a0};
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic rand_inputs();
    rst        = ($urandom_range(0, 49) == 0);
    wr_en      = 1'($urandom_range(0, 1));
    wr_addr    = 5'($urandom_range(0, 31));
    wr_data    = $urandom;
    claim_en   = ($urandom_range(0, 3) == 0);
    claim_addr = 5'($urandom_range(0, NR - 1));
    flush      = ($urandom_range(0, 15) == 0);
    rd_en      = 2'($urandom_range(0, 3));
    rd_addr[4:0] = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
    rd_addr[9:5] = ($urandom_range(0, 3) == 0) ? claim_addr : 5'($urandom_range(0, 31));
  endtask

  vec_t vecs [16];

  initial begin
    // rst we  wa     wd          ce  ca     fl  ren    a0     a1     ev     d0             d1             b0  b1  bv
    vecs[0]  = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 2'b11, 5'd5,  5'd5,
                 2'b00, 32'h0,        32'h0,        1'b0, 1'b0, 24'h0};
    vecs[1]  = '{1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  1'b0, 2'b11, 5'd5,  5'd4,
                 2'b11, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 24'h0};
    vecs[2]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  1'b0, 2'b01, 5'd7,  5'd0,
                 2'b01, 32'h0,        32'h0,        1'b1, 1'b0, 24'h80};
    vecs[3]  = '{1'b0, 1'b1, 5'd7,  32'h12,       1'b0, 5'd0,  1'b0, 2'b11, 5'd7,  5'd7,
                 2'b11, 32'h12,       32'h12,       1'b0, 1'b0, 24'h0};
    vecs[4]  = '{1'b0, 1'b1, 5'd3,  32'hA5,       1'b1, 5'd3,  1'b0, 2'b10, 5'd0,  5'd3,
                 2'b10, 32'h12,       32'hA5,       1'b0, 1'b1, 24'h8};
    vecs[5]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b1, 2'b11, 5'd3,  5'd5,
                 2'b11, 32'hA5,       32'hDEADBEEF, 1'b0, 1'b0, 24'h0};
    vecs[6]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  1'b0, 2'b00, 5'd0,  5'd0,
                 2'b00, 32'hA5,       32'hDEADBEEF, 1'b0, 1'b0, 24'h200};
    vecs[7]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 2'b11, 5'd9,  5'd7,
                 2'b11, 32'h0,        32'h12,       1'b1, 1'b0, 24'h200};
    vecs[8]  = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 2'b11, 5'd5,  5'd7,
                 2'b00, 32'h0,        32'h0,        1'b0, 1'b0, 24'h0};
    vecs[9]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 2'b11, 5'd9,  5'd5,
                 2'b11, 32'h0,        32'h0,        1'b0, 1'b0, 24'h0};
    vecs[10] = '{1'b0, 1'b1, 5'd30, 32'h55,       1'b0, 5'd0,  1'b0, 2'b11, 5'd30, 5'd23,
                 2'b11, 32'h0,        32'h0,        1'b0, 1'b0, 24'h0};
    vecs[11] = '{1'b0, 1'b1, 5'd23, 32'h2323,     1'b0, 5'd0,  1'b0, 2'b01, 5'd23, 5'd0,
                 2'b01, 32'h2323,     32'h0,        1'b0, 1'b0, 24'h0};
    vecs[12] = '{1'b0, 1'b1, 5'd0,  32'hFF,       1'b1, 5'd0,  1'b0, 2'b11, 5'd0,  5'd0,
                 2'b11, Z ? 32'h0 : 32'hFF, Z ? 32'h0 : 32'hFF, !Z, !Z, {23'h0, !Z}};
    vecs[13] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 2'b10, 5'd0,  5'd31,
                 2'b10, Z ? 32'h0 : 32'hFF, 32'h0,  !Z, 1'b0, {23'h0, !Z}};
    vecs[14] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd4,  1'b1, 2'b01, 5'd4,  5'd0,
                 2'b01, 32'h0,        32'h0,        1'b0, 1'b0, 24'h0};
    vecs[15] = '{1'b0, 1'b1, 5'd6,  32'h66,       1'b1, 5'd4,  1'b0, 2'b11, 5'd4,  5'd6,
                 2'b11, 32'h0,        32'h66,       1'b1, 1'b0, 24'h10};

    for (int i = 0; i < 16; i++) begin
      apply(vecs[i]);
      chk($sformatf("vec%0d rd_valid", i), 64'(rd_valid), 64'(vecs[i].e_valid));
      chk($sformatf("vec%0d rd_data0", i), 64'(rd_data[31:0]), 64'(vecs[i].e_d0));
      chk($sformatf("vec%0d rd_data1", i), 64'(rd_data[63:32]), 64'(vecs[i].e_d1));
      chk($sformatf("vec%0d rd_busy", i), 64'(rd_busy), 64'({vecs[i].e_b1, vecs[i].e_b0}));
      chk($sformatf("vec%0d busy_vec", i), 64'(busy_vec), 64'(vecs[i].e_bv));
    end

    for (int c = 0; c < 600; c++) begin
      rand_inputs();
      @(posedge clk);
      model_step();
      #1;
      chk($sformatf("rand%0d rd_valid", c), 64'(rd_valid), 64'(m_valid));
      chk($sformatf("rand%0d rd_data0", c), 64'(rd_data[31:0]), 64'(m_data[0]));
      chk($sformatf("rand%0d rd_data1", c), 64'(rd_data[63:32]), 64'(m_data[1]));
      chk($sformatf("rand%0d rd_busy", c), 64'(rd_busy), 64'({m_bsy[1], m_bsy[0]}));
      chk($sformatf("rand%0d busy_vec", c), 64'(busy_vec), 64'(model_busy_vec()));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
